ahb_lite_master_arb: RTL and testbench
======================================

Name: ahb_lite_master_arb

Overview:
- Two-requester AHB-Lite master that shares one bus port to the UART AHB slave.
- Both the sequence/config engine (requester 0) and the host/test path (requester 1) issue single read/write transfers through it.
- Performs round-robin arbitration and sequences address and data phases, including wait states and the two-cycle ERROR response.
- Returns one response per accepted request.

Parameters:
- AW, `AHB_ADDR_WIDTH: address width.
- DW, `AHB_DATA_WIDTH: data width (32 or 64).
- HPROT_VAL, 4'b0011: constant HPROT (data access, privileged).

Ports:
- HCLK  in  1  bus clock; single clock domain.
- HRESET  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  request N (N=0,1) pending; fields held stable until reqN_ready.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  AW  transfer address.
- reqN_wdata  in  DW  write data.
- reqN_size  in  3  HSIZE encoding.
- reqN_ready  out  1  request N accepted this cycle (valid&ready).
- rspN_valid  out  1  one-cycle response strobe for N.
- rspN_rdata  out  DW  captured HRDATA (0 for writes).
- rspN_err  out  1  transfer ended with ERROR or was rejected.
- HADDR  out  AW  address-phase address.
- HBURST  out  3  always 3'b000 (SINGLE).
- HMASTLOCK  out  1  always 0.
- HPROT  out  4  HPROT_VAL.
- HSIZE  out  3  address-phase size.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  address-phase direction.
- HWDATA  out  DW  data-phase write data.
- HSEL  out  1  high during address phase only.
- HRDATA  in  DW  read data.
- HREADYOUT  in  1  slave ready.
- HRESP  in  1  slave error response.
- interrupt  in  1  UART interrupt; used only with the optional feature.

Behaviour:
- Reset (async, HRESET=1) forces:
  - HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - All reqN_ready, rspN_valid, rspN_err = 0; rspN_rdata=0.
  - FSM=IDLE; last-grant pointer=1, so requester 0 wins first.
  - Assertion mid-transfer abandons it with no response; bus outputs go idle immediately.
- FSM states IDLE, ADDR, DATA, ERR2.
- IDLE:
  - reqN_ready is combinational = (state==IDLE) & winner==N.
  - Winner is round-robin: if both valid, the one not granted last wins; if one is valid, it wins.
  - On accept: latch write/addr/wdata/size and owner, update pointer to winner, go ADDR.
  - Size check: if reqN_size > log2(DW/8), accept but issue no bus transfer. Next cycle rspN_valid=1, err=1; stay IDLE.
- ADDR (one cycle): HTRANS=NONSEQ, HSEL=1, HADDR/HWRITE/HSIZE from latch. Go DATA.
- DATA:
  - HTRANS=IDLE, HSEL=0, HWDATA=latched wdata, held until the phase ends.
  - HREADYOUT=1 & HRESP=0: capture HRDATA if read (else 0); rsp strobe next cycle with err=0; go IDLE.
  - HREADYOUT=0 & HRESP=0: wait state; stay in DATA, no limit.
  - HREADYOUT=0 & HRESP=1: go ERR2.
  - HREADYOUT=1 & HRESP=1 (protocol violation): treat as error completion.
- ERR2: wait for HREADYOUT=1, then rsp strobe with err=1, rdata=0, go IDLE.
- Latency, zero-wait case: accept cycle 0, address phase cycle 1, data phase cycle 2, rspN_valid cycle 3. Next accept is possible in cycle 3. Each wait state adds one cycle.
- Only the owning requester's rsp outputs change; rspN_rdata/err hold their value between strobes.
- Arbitration is evaluated only in IDLE. A request arriving mid-transfer waits.

Optional Feature:
- Macro AHB_IRQ_PRIO_EN.
- Defined: when interrupt=1 during IDLE arbitration and req0_valid=1, requester 0 wins regardless of pointer, and the pointer is not updated by that grant.
- Undefined: interrupt is ignored; pure round-robin.

Test Plan:
- Reset then req0 write addr=0x04 wdata=0x55 size=2, HREADYOUT=1 -> HTRANS=10 at cycle 1 with HADDR=0x04, HWDATA=0x55 at cycle 2, rsp0_valid=1 err=0 at cycle 3.
- req1 read addr=0x08, slave inserts 3 wait states then HRDATA=0xA5 -> HWDATA/phase held 4 cycles, rsp1_valid with rdata=0xA5 at cycle 6.
- req0 and req1 valid together for 4 back-to-back transfers -> grants 0,1,0,1, each response to the correct requester.
- Slave ERROR (HREADYOUT=0/HRESP=1, then 1/1) on req0 read -> HTRANS=00 during error, rsp0_err=1, rsp0_rdata=0.
- req1 size=3'b011 with DW=32 -> no HTRANS=10 issued, rsp1_valid=1 err=1 one cycle after accept.
- HRESET pulsed during a wait-stated DATA phase -> HTRANS=00 and HSEL=0 immediately, no rsp strobe, next grant goes to req0. With AHB_IRQ_PRIO_EN and interrupt=1, req0 wins two consecutive contested grants.

Source files
------------

// File: rtl/ahb_lite_master_arb.sv
// Two-requester AHB-Lite single-transfer master with round-robin arbitration.
// Optional macro AHB_IRQ_PRIO_EN: an active interrupt lets requester 0 win arbitration.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_lite_master_arb #(
  parameter int         AW        = `AHB_ADDR_WIDTH,
  parameter int         DW        = `AHB_DATA_WIDTH,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [2:0]    req0_size,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [2:0]    req1_size,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic [AW-1:0] HADDR,
  output logic [2:0]    HBURST,
  output logic          HMASTLOCK,
  output logic [3:0]    HPROT,
  output logic [2:0]    HSIZE,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [DW-1:0] HWDATA,
  output logic          HSEL,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADYOUT,
  input  logic          HRESP,
  input  logic          interrupt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_ERR2 = 2'd3} state_t;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(DW / 8));

  state_t        r_state, w_next;
  logic          r_last, r_owner, r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_size;
  logic [1:0]    r_rsp_valid, r_rsp_err;
  logic [DW-1:0] r_rsp0_rdata, r_rsp1_rdata;

  logic          w_irq_force, w_win, w_sel_valid, w_accept, w_size_ok;
  logic          w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [2:0]    w_sel_size;
  logic          w_done, w_done_id, w_done_err;
  logic [DW-1:0] w_done_rdata;
  logic [1:0]    w_htrans;
  logic          w_hsel;
  logic [DW-1:0] w_hwdata;

`ifdef AHB_IRQ_PRIO_EN
  assign w_irq_force = interrupt & req0_valid;
`else
  logic w_unused_irq;
  assign w_unused_irq = interrupt;
  assign w_irq_force  = 1'b0;
`endif

  // Round-robin winner; the requester not granted last wins a contest.
  always_comb begin
    if (w_irq_force) begin
      w_win = 1'b0;
    end else if (req0_valid && req1_valid) begin
      w_win = ~r_last;
    end else if (req1_valid) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
  end

  assign w_sel_valid = w_win ? req1_valid : req0_valid;
  assign w_sel_write = w_win ? req1_write : req0_write;
  assign w_sel_addr  = w_win ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_win ? req1_wdata : req0_wdata;
  assign w_sel_size  = w_win ? req1_size  : req0_size;
  assign w_accept    = (r_state == S_IDLE) && w_sel_valid && !HRESET;
  assign w_size_ok   = (w_sel_size <= SIZE_MAX);
  assign req0_ready  = w_accept && !w_win;
  assign req1_ready  = w_accept && w_win;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_size_ok) w_next = S_ADDR;
        else                       w_next = S_IDLE;
      end
      S_ADDR: w_next = S_DATA;
      S_DATA: begin
        if (HREADYOUT)  w_next = S_IDLE;
        else if (HRESP) w_next = S_ERR2;
        else            w_next = S_DATA;
      end
      S_ERR2: begin
        if (HREADYOUT) w_next = S_IDLE;
        else           w_next = S_ERR2;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_htrans = 2'b00;
    w_hsel   = 1'b0;
    w_hwdata = {DW{1'b0}};
    case (r_state)
      S_ADDR: begin
        w_htrans = 2'b10;
        w_hsel   = 1'b1;
      end
      S_DATA, S_ERR2: w_hwdata = r_wdata;
      default: ;
    endcase
  end

  // Completion event: rejected size in IDLE, or the final data/error cycle on the bus.
  always_comb begin
    w_done       = 1'b0;
    w_done_id    = r_owner;
    w_done_err   = 1'b0;
    w_done_rdata = {DW{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_size_ok) begin
          w_done     = 1'b1;
          w_done_id  = w_win;
          w_done_err = 1'b1;
        end else begin
          w_done = 1'b0;
        end
      end
      S_DATA: begin
        if (HREADYOUT) begin
          w_done       = 1'b1;
          w_done_err   = HRESP;
          w_done_rdata = (HRESP || r_write) ? {DW{1'b0}} : HRDATA;
        end else begin
          w_done = 1'b0;
        end
      end
      S_ERR2: begin
        if (HREADYOUT) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end else begin
          w_done = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_wdata <= {DW{1'b0}};
      r_size  <= 3'd0;
    end else if (w_accept) begin
      r_owner <= w_win;
      r_write <= w_sel_write;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_size  <= w_sel_size;
      if (!w_irq_force) r_last <= w_win;
    end
  end

  // Only the owning requester's response fields change; they hold between strobes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_err    <= 2'b00;
      r_rsp0_rdata <= {DW{1'b0}};
      r_rsp1_rdata <= {DW{1'b0}};
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_done) begin
        r_rsp_valid[w_done_id] <= 1'b1;
        r_rsp_err[w_done_id]   <= w_done_err;
        if (w_done_id) r_rsp1_rdata <= w_done_rdata;
        else           r_rsp0_rdata <= w_done_rdata;
      end
    end
  end

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_err   = r_rsp_err[0];
  assign rsp1_err   = r_rsp_err[1];
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;
  assign HADDR      = r_addr;
  assign HWRITE     = r_write;
  assign HSIZE      = r_size;
  assign HTRANS     = w_htrans;
  assign HSEL       = w_hsel;
  assign HWDATA     = w_hwdata;
  assign HBURST     = 3'b000;
  assign HMASTLOCK  = 1'b0;
  assign HPROT      = HPROT_VAL;

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Scoreboard bench for ahb_lite_master_arb: requester drivers, slave model, response monitor.
`timescale 1ns/1ps
module tb_ahb_lite_master_arb;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAXSZ = $clog2(DW / 8);

  logic HCLK = 1'b0, HRESET = 1'b1;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic [2:0] req0_size = 3'd0, req1_size = 3'd0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata, HWDATA;
  logic [AW-1:0] HADDR;
  logic [2:0] HBURST, HSIZE;
  logic HMASTLOCK, HWRITE, HSEL;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [DW-1:0] HRDATA = '0;
  logic HREADYOUT = 1'b1, HRESP = 1'b0, interrupt = 1'b0;

  ahb_lite_master_arb #(.AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_size(req0_size), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_size(req1_size), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HSEL(HSEL),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .interrupt(interrupt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { bit err; logic [DW-1:0] rdata; int cyc; } rsp_t;
  typedef struct {
    int acc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata;
    logic [2:0] size; int waits; int ek;  // ek: 0 okay, 1 two-cycle error, 2 ready+error
  } bus_t;

  rsp_t q_rsp0[$], q_rsp1[$];
  bus_t q_bus[$];
  int checks = 0, errors = 0, cyc = 0;
  bit model_last = 1'b1;
  bit rnd_on = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester driver: holds the request until accepted, then records what must come back.
  task automatic issue(input int n, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [2:0] sz, input int waits, input int ek, input logic [DW-1:0] rd);
    int t; bit done; bit force0; bit expw; rsp_t r; bus_t b;
    if (n == 0) begin
      req0_write = wr; req0_addr = a; req0_wdata = wd; req0_size = sz; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = a; req1_wdata = wd; req1_size = sz; req1_valid = 1'b1;
    end
    t = 0; done = 1'b0;
    while (!done) begin
      @(negedge HCLK);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        force0 = 1'b0;
`ifdef AHB_IRQ_PRIO_EN
        force0 = interrupt && req0_valid;
`endif
        if (force0) expw = 1'b0;
        else if (req0_valid && req1_valid) expw = ~model_last;
        else expw = (n == 1);
        chk($sformatf("grant_to_req%0d", n), 64'(n == 1), 64'(expw));
        if (!force0) model_last = (n == 1);
        if (int'(sz) > MAXSZ) begin
          r.err = 1'b1; r.rdata = '0; r.cyc = cyc + 1;
        end else begin
          r.err = (ek != 0);
          r.rdata = (ek != 0 || wr) ? '0 : rd;
          r.cyc = cyc + waits + ((ek == 1) ? 4 : 3);
          b.acc = cyc; b.wr = wr; b.addr = a; b.wdata = wd; b.rdata = rd;
          b.size = sz; b.waits = waits; b.ek = ek;
          q_bus.push_back(b);
        end
        if (n == 0) q_rsp0.push_back(r);
        else q_rsp1.push_back(r);
        done = 1'b1;
      end else begin
        t++;
        if (t > 300) begin
          checks++; errors++;
          $display("FAIL accept_timeout_req%0d: got no ready expected accept within 300 cycles", n);
          done = 1'b1;
        end
      end
      @(posedge HCLK); #1;
    end
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic check_rsp(input int n, input logic e, input logic [DW-1:0] d);
    rsp_t x;
    if ((n == 0 && q_rsp0.size() == 0) || (n == 1 && q_rsp1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_rsp%0d: got strobe expected none (cycle %0d)", n, cyc);
    end else begin
      if (n == 0) x = q_rsp0.pop_front();
      else x = q_rsp1.pop_front();
      chk($sformatf("rsp%0d_err", n), 64'(e), 64'(x.err));
      chk($sformatf("rsp%0d_rdata", n), 64'(d), 64'(x.rdata));
      chk($sformatf("rsp%0d_cycle", n), 64'(cyc), 64'(x.cyc));
    end
  endtask

  // Response monitor.
  initial forever begin
    @(negedge HCLK);
    if (rsp0_valid) check_rsp(0, rsp0_err, rsp0_rdata);
    if (rsp1_valid) check_rsp(1, rsp1_err, rsp1_rdata);
  end

  // Slave model: checks each address phase against the accept order and plays out the data phase.
  initial begin
    bus_t b; int k; int total; bit ab;
    forever begin
      @(negedge HCLK);
      if (!HRESET && HTRANS == 2'b10) begin
        if (q_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_nonseq: got HTRANS=10 expected idle bus (cycle %0d)", cyc);
        end else begin
          b = q_bus.pop_front();
          chk("addr_phase_cycle", 64'(cyc), 64'(b.acc + 1));
          chk("HADDR", 64'(HADDR), 64'(b.addr));
          chk("HWRITE", 64'(HWRITE), 64'(b.wr));
          chk("HSIZE", 64'(HSIZE), 64'(b.size));
          chk("HSEL_addr", 64'(HSEL), 64'd1);
          total = b.waits + ((b.ek == 1) ? 2 : 1);
          k = 0; ab = 1'b0;
          while (k < total && !ab) begin
            @(posedge HCLK); #1;
            if (HRESET) ab = 1'b1;
            else begin
              HRDATA = $urandom;
              if (k < b.waits) begin HREADYOUT = 1'b0; HRESP = 1'b0; end
              else if (b.ek == 1) begin HREADYOUT = (k > b.waits); HRESP = 1'b1; end
              else if (b.ek == 2) begin HREADYOUT = 1'b1; HRESP = 1'b1; end
              else begin HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = b.rdata; end
              @(negedge HCLK);
              if (HRESET) ab = 1'b1;
              else begin
                chk("HTRANS_data", 64'(HTRANS), 64'd0);
                chk("HSEL_data", 64'(HSEL), 64'd0);
                if (b.wr) chk("HWDATA", 64'(HWDATA), 64'(b.wdata));
              end
            end
            k++;
          end
          if (!ab) begin @(posedge HCLK); #1; end
          HREADYOUT = 1'b1; HRESP = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge HCLK); #1;
    if (rnd_on) interrupt = ($urandom_range(0, 3) == 0);
  end

  task automatic drain();
    int t;
    t = 0;
    while ((q_rsp0.size() + q_rsp1.size() + q_bus.size()) != 0 && t < 500) begin
      @(posedge HCLK); t++;
    end
    #1;
    chk("drain_pending", 64'(q_rsp0.size() + q_rsp1.size() + q_bus.size()), 64'd0);
  endtask

  task automatic rnd_req(input int n);
    int g; int r; int ek; logic [2:0] sz;
    for (int i = 0; i < 20; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge HCLK); #1; end
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      ek = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      issue(n, 1'($urandom_range(0, 1)), $urandom, $urandom, sz, $urandom_range(0, 3), ek, $urandom);
    end
  endtask

  initial begin
    req0_valid = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_HTRANS", 64'(HTRANS), 64'd0);
    chk("rst_HSEL", 64'(HSEL), 64'd0);
    chk("rst_HADDR", 64'(HADDR), 64'd0);
    chk("rst_HWRITE", 64'(HWRITE), 64'd0);
    chk("rst_HSIZE", 64'(HSIZE), 64'd0);
    chk("rst_HWDATA", 64'(HWDATA), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rst_rsp_err", 64'({rsp0_err, rsp1_err}), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp0_rdata | rsp1_rdata), 64'd0);
    chk("HBURST", 64'(HBURST), 64'd0);
    chk("HMASTLOCK", 64'(HMASTLOCK), 64'd0);
    chk("HPROT", 64'(HPROT), 64'h3);
    req0_valid = 1'b0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    issue(0, 1'b1, 32'h04, 32'h55, 3'd2, 0, 0, 32'h0);
    issue(1, 1'b0, 32'h08, 32'h0, 3'd2, 3, 0, 32'hA5);
    drain();

    fork
      begin
        issue(0, 1'b1, 32'h100, 32'h1111, 3'd2, 0, 0, 32'h0);
        issue(0, 1'b0, 32'h104, 32'h0, 3'd1, 1, 0, 32'h2222);
      end
      begin
        issue(1, 1'b0, 32'h200, 32'h0, 3'd0, 0, 0, 32'h3333);
        issue(1, 1'b1, 32'h204, 32'h4444, 3'd2, 2, 0, 32'h0);
      end
    join
    drain();

    issue(0, 1'b0, 32'h10, 32'h0, 3'd2, 0, 1, 32'hDEADBEEF);
    issue(1, 1'b0, 32'h14, 32'h0, 3'd3, 0, 0, 32'h1);
    issue(0, 1'b0, 32'h18, 32'h0, 3'd2, 1, 2, 32'hCAFE);
    drain();

    issue(1, 1'b0, 32'h20, 32'h0, 3'd2, 30, 0, 32'h77);
    repeat (4) @(posedge HCLK);
    #2;
    HRESET = 1'b1;
    #1;
    chk("midrst_HTRANS", 64'(HTRANS), 64'd0);
    chk("midrst_HSEL", 64'(HSEL), 64'd0);
    if (q_rsp1.size() != 0) void'(q_rsp1.pop_back());
    model_last = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    fork
      issue(0, 1'b1, 32'h30, 32'hABCD, 3'd2, 0, 0, 32'h0);
      issue(1, 1'b0, 32'h34, 32'h0, 3'd2, 0, 0, 32'h5A5A);
    join
    drain();

`ifdef AHB_IRQ_PRIO_EN
    interrupt = 1'b1;
    fork
      begin
        issue(0, 1'b0, 32'h40, 32'h0, 3'd2, 0, 0, 32'h61);
        issue(0, 1'b0, 32'h44, 32'h0, 3'd2, 0, 0, 32'h62);
      end
      issue(1, 1'b0, 32'h48, 32'h0, 3'd2, 0, 0, 32'h63);
    join
    interrupt = 1'b0;
    drain();
`endif

    rnd_on = 1'b1;
    fork
      rnd_req(0);
      rnd_req(1);
    join
    rnd_on = 1'b0;
    interrupt = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
